// File: rtl/if_stage_pkg.sv
// Shared bus widths and bus layouts for the fetch stage and the stages around it.
package if_stage_pkg;

    localparam int         FS_TO_DS_BUS_WD = 64;
    localparam int         BR_BUS_WD       = 33;
    localparam logic [1:0] SRAM_SIZE_WORD  = 2'b10;

    typedef struct packed {
        logic        br_taken;
        logic [31:0] br_target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch (pre-IF + IF): next-PC generation, single-outstanding SRAM fetch,
// instruction buffering toward id_stage, and branch redirect with wrong-path squashing.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    br_bus_t     br;
    fs_to_ds_t   fs_pkt;
    logic        br_taken;
    logic [31:0] br_target;

    logic        fs_valid;
    logic        ibuf_valid;
    logic        br_buf_valid;
    logic        discard;
    logic        req_en;
    logic        pending;
    logic [31:0] fs_pc;
    logic [31:0] ibuf;
    logic [31:0] br_buf_target;
    logic [31:0] nextpc;

    logic        data_live;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        pending_unreturned;
    logic        req_accept;
    logic        handoff;
    logic        ibuf_load;

    assign br        = br_bus;
    assign br_taken  = br.br_taken;
    assign br_target = br.br_target;

    // pre-IF: next fetch address and request gating
    assign nextpc = br_buf_valid ? br_buf_target :
                    br_taken     ? br_target     :
                                   fs_pc + 32'd4;

    // Returning data frees the slot in the same cycle, so back-to-back fetches need no bubble.
    assign pending_unreturned = pending & ~inst_sram_data_ok;
    assign data_live          = inst_sram_data_ok & ~discard;
    assign fs_ready_go        = ibuf_valid | data_live;
    assign fs_allowin         = ~fs_valid | (fs_ready_go & ds_allowin);
    assign inst_sram_req      = req_en & fs_allowin & ~discard & ~pending_unreturned;
    assign req_accept         = inst_sram_req & inst_sram_addr_ok;

    assign inst_sram_addr  = nextpc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SRAM_SIZE_WORD;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

    // IF: deliver from ibuf or straight off the read-data bus
    assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;
    assign handoff        = fs_to_ds_valid & ds_allowin;
    assign ibuf_load      = fs_valid & data_live & ~ds_allowin & ~br_taken;
    assign fs_pkt.inst    = ibuf_valid ? ibuf : inst_sram_rdata;
    assign fs_pkt.pc      = fs_pc;
    assign fs_to_ds_bus   = fs_pkt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid     <= 1'b0;
            ibuf_valid   <= 1'b0;
            br_buf_valid <= 1'b0;
            discard      <= 1'b0;
            req_en       <= 1'b0;
            pending      <= 1'b0;
            fs_pc        <= RESET_PC - 32'd4;
        end else begin
            req_en <= 1'b1;

            if (req_accept) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end else if (br_taken | handoff) begin
                fs_valid <= 1'b0;
            end

            if (br_taken | handoff)
                ibuf_valid <= 1'b0;
            else if (ibuf_load)
                ibuf_valid <= 1'b1;

            if (req_accept)
                br_buf_valid <= 1'b0;
            else if (br_taken)
                br_buf_valid <= 1'b1;

            if (req_accept)
                pending <= 1'b1;
            else if (inst_sram_data_ok)
                pending <= 1'b0;

            // A squashed fetch still in flight must have its response swallowed.
            if (br_taken & pending_unreturned)
                discard <= 1'b1;
            else if (inst_sram_data_ok)
                discard <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ibuf_load)
            ibuf <= inst_sram_rdata;
        if (br_taken & ~req_accept)
            br_buf_target <= br_target;
    end

endmodule
